// File: rtl/axi_lat_shaper.sv
// Runtime-programmable AXI latency injector: one delay FIFO per channel, each beat held for
// a base latency plus optional LFSR jitter sampled when the beat is accepted.

package AxiLatShaperPkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

endpackage

module AxiLatShaperChan #(
  parameter type         data_t       = logic,
  parameter int unsigned Depth        = 4,
  parameter int unsigned LatWidth     = 8,
  parameter bit          EnableJitter = 1'b0,
  parameter logic [15:0] Seed         = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [LatWidth-1:0] lat_i,
  input  logic [LatWidth-1:0] jitter_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  data_t               data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output data_t               data_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  typedef logic [AddrW:0] ptr_t;

  ptr_t                wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LatWidth-1:0] cnt_q [Depth];
  logic [LatWidth-1:0] cnt_d [Depth];
  data_t               mem_q [Depth];
  logic [15:0]         lfsr_q, lfsr_d;
  logic [AddrW-1:0]    wrIdx, rdIdx;
  logic                empty, full, push, pop;
  logic [LatWidth-1:0] jitter, loadLat;
  logic [LatWidth:0]   latSum;

  assign wrIdx   = wrPtr_q[AddrW-1:0];
  assign rdIdx   = rdPtr_q[AddrW-1:0];
  assign empty   = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AddrW] != rdPtr_q[AddrW]) && (wrIdx == rdIdx);
  assign ready_o = !full;
  assign valid_o = !empty && (cnt_q[rdIdx] == '0);
  assign data_o  = valid_o ? mem_q[rdIdx] : '0;
  assign push    = valid_i && !full;
  assign pop     = valid_o && ready_i;

  // Jitter is sampled from the LFSR state in the accepting cycle; the sum saturates.
  assign jitter  = EnableJitter ? (lfsr_q[LatWidth-1:0] & jitter_i) : '0;
  assign latSum  = {1'b0, lat_i} + {1'b0, jitter};
  assign loadLat = latSum[LatWidth] ? '1 : latSum[LatWidth-1:0];
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    wrPtr_d = wrPtr_q + ptr_t'(push);
    rdPtr_d = rdPtr_q + ptr_t'(pop);
    for (int i = 0; i < Depth; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LatWidth'(1) : cnt_q[i];
      if (push && (wrIdx == AddrW'(i))) cnt_d[i] = loadLat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      lfsr_q  <= Seed;
      for (int i = 0; i < Depth; i++) cnt_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      lfsr_q  <= lfsr_d;
      for (int i = 0; i < Depth; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Payload storage needs no reset: data_o is masked whenever the head is not valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrIdx] <= data_i;
  end

endmodule

module axi_lat_shaper #(
  parameter type         aw_chan_t    = AxiLatShaperPkg::aw_chan_t,
  parameter type         w_chan_t     = AxiLatShaperPkg::w_chan_t,
  parameter type         b_chan_t     = AxiLatShaperPkg::b_chan_t,
  parameter type         ar_chan_t    = AxiLatShaperPkg::ar_chan_t,
  parameter type         r_chan_t     = AxiLatShaperPkg::r_chan_t,
  parameter type         req_t        = AxiLatShaperPkg::req_t,
  parameter type         resp_t       = AxiLatShaperPkg::resp_t,
  parameter int unsigned Depth        = 4,
  parameter int unsigned LatWidth     = 8,
  parameter bit          EnableJitter = 1'b0,
  parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [LatWidth-1:0] cfg_req_lat_i,
  input  logic [LatWidth-1:0] cfg_resp_lat_i,
  input  logic [LatWidth-1:0] cfg_req_jitter_i,
  input  logic [LatWidth-1:0] cfg_resp_jitter_i,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i
);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_bad_depth
    $error("axi_lat_shaper: Depth must be a power of two and at least 2");
  end
  if (LatWidth < 1 || LatWidth > 16) begin : gen_bad_latwidth
    $error("axi_lat_shaper: LatWidth must be in 1..16");
  end
  if (LfsrSeed == 16'h0000) begin : gen_bad_seed
    $error("axi_lat_shaper: LfsrSeed must be nonzero");
  end

  logic     awReady, wReady, arReady, bReady, rReady;
  logic     awValid, wValid, arValid, bValid, rValid;
  aw_chan_t awOut;
  w_chan_t  wOut;
  ar_chan_t arOut;
  b_chan_t  bOut;
  r_chan_t  rOut;

  AxiLatShaperChan #(
    .data_t(aw_chan_t), .Depth(Depth), .LatWidth(LatWidth),
    .EnableJitter(EnableJitter), .Seed(LfsrSeed ^ 16'd1)
  ) i_aw (
    .clk_i, .rst_ni, .lat_i(cfg_req_lat_i), .jitter_i(cfg_req_jitter_i),
    .valid_i(slv_req_i.aw_valid), .ready_o(awReady), .data_i(slv_req_i.aw),
    .valid_o(awValid), .ready_i(mst_resp_i.aw_ready), .data_o(awOut)
  );

  AxiLatShaperChan #(
    .data_t(w_chan_t), .Depth(Depth), .LatWidth(LatWidth),
    .EnableJitter(EnableJitter), .Seed(LfsrSeed ^ 16'd2)
  ) i_w (
    .clk_i, .rst_ni, .lat_i(cfg_req_lat_i), .jitter_i(cfg_req_jitter_i),
    .valid_i(slv_req_i.w_valid), .ready_o(wReady), .data_i(slv_req_i.w),
    .valid_o(wValid), .ready_i(mst_resp_i.w_ready), .data_o(wOut)
  );

  AxiLatShaperChan #(
    .data_t(ar_chan_t), .Depth(Depth), .LatWidth(LatWidth),
    .EnableJitter(EnableJitter), .Seed(LfsrSeed ^ 16'd3)
  ) i_ar (
    .clk_i, .rst_ni, .lat_i(cfg_req_lat_i), .jitter_i(cfg_req_jitter_i),
    .valid_i(slv_req_i.ar_valid), .ready_o(arReady), .data_i(slv_req_i.ar),
    .valid_o(arValid), .ready_i(mst_resp_i.ar_ready), .data_o(arOut)
  );

  AxiLatShaperChan #(
    .data_t(b_chan_t), .Depth(Depth), .LatWidth(LatWidth),
    .EnableJitter(EnableJitter), .Seed(LfsrSeed ^ 16'd4)
  ) i_b (
    .clk_i, .rst_ni, .lat_i(cfg_resp_lat_i), .jitter_i(cfg_resp_jitter_i),
    .valid_i(mst_resp_i.b_valid), .ready_o(bReady), .data_i(mst_resp_i.b),
    .valid_o(bValid), .ready_i(slv_req_i.b_ready), .data_o(bOut)
  );

  AxiLatShaperChan #(
    .data_t(r_chan_t), .Depth(Depth), .LatWidth(LatWidth),
    .EnableJitter(EnableJitter), .Seed(LfsrSeed ^ 16'd5)
  ) i_r (
    .clk_i, .rst_ni, .lat_i(cfg_resp_lat_i), .jitter_i(cfg_resp_jitter_i),
    .valid_i(mst_resp_i.r_valid), .ready_o(rReady), .data_i(mst_resp_i.r),
    .valid_o(rValid), .ready_i(slv_req_i.r_ready), .data_o(rOut)
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = awOut;
    mst_req_o.aw_valid = awValid;
    mst_req_o.w        = wOut;
    mst_req_o.w_valid  = wValid;
    mst_req_o.ar       = arOut;
    mst_req_o.ar_valid = arValid;
    mst_req_o.b_ready  = bReady;
    mst_req_o.r_ready  = rReady;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = awReady;
    slv_resp_o.w_ready  = wReady;
    slv_resp_o.ar_ready = arReady;
    slv_resp_o.b        = bOut;
    slv_resp_o.b_valid  = bValid;
    slv_resp_o.r        = rOut;
    slv_resp_o.r_valid  = rValid;
  end

endmodule

// File: tb/tb_axi_lat_shaper.sv
// Directed bench for axi_lat_shaper: latency, backpressure, head-of-line order,
// saturating jitter and asynchronous reset behaviour.

module tb_axi_lat_shaper;
  import AxiLatShaperPkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] reqLat, respLat, reqJit, respJit;
  req_t       slvReq, mstReq;
  resp_t      slvResp, mstResp;
  int         testsRun = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  axi_lat_shaper #(
    .Depth(4), .LatWidth(8), .EnableJitter(1'b1), .LfsrSeed(16'hACE1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_lat_i(reqLat), .cfg_resp_lat_i(respLat),
    .cfg_req_jitter_i(reqJit), .cfg_resp_jitter_i(respJit),
    .slv_req_i(slvReq), .slv_resp_o(slvResp),
    .mst_req_o(mstReq), .mst_resp_i(mstResp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic validOf(input int ch);
    case (ch)
      0:       return mstReq.aw_valid;
      1:       return mstReq.w_valid;
      2:       return mstReq.ar_valid;
      3:       return slvResp.b_valid;
      default: return slvResp.r_valid;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat on the given channel for exactly one cycle.
  task automatic applyStimulus(input int ch, input logic [31:0] payload);
    case (ch)
      0: begin slvReq.aw_valid = 1'b1; slvReq.aw.addr = payload; end
      1: begin slvReq.w_valid = 1'b1; slvReq.w.data = payload; end
      2: begin slvReq.ar_valid = 1'b1; slvReq.ar.addr = payload; end
      3: begin mstResp.b_valid = 1'b1; mstResp.b.id = payload[3:0]; end
      default: begin mstResp.r_valid = 1'b1; mstResp.r.data = payload; end
    endcase
    step();
    slvReq.aw_valid = 1'b0;
    slvReq.w_valid  = 1'b0;
    slvReq.ar_valid = 1'b0;
    mstResp.b_valid = 1'b0;
    mstResp.r_valid = 1'b0;
  endtask

  // Cycles waited from the current cycle until the channel output goes valid (capped).
  task automatic measure(input int ch, output int n);
    n = 0;
    while (!validOf(ch) && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int accepted;
    int sent;
    int minL;
    int maxL;
    int seen;
    logic sawSat;
    logic acc;
    logic [31:0] got[$];

    slvReq   = '0;
    mstResp  = '0;
    slvReq.b_ready   = 1'b1;
    slvReq.r_ready   = 1'b1;
    mstResp.aw_ready = 1'b1;
    mstResp.w_ready  = 1'b1;
    mstResp.ar_ready = 1'b1;
    reqLat  = 8'd0;
    respLat = 8'd0;
    reqJit  = 8'd0;
    respJit = 8'd0;
    rst_n   = 1'b0;

    #1;
    checkOutput("rst_aw_ready", 64'(slvResp.aw_ready), 64'd1);
    checkOutput("rst_w_ready", 64'(slvResp.w_ready), 64'd1);
    checkOutput("rst_ar_ready", 64'(slvResp.ar_ready), 64'd1);
    checkOutput("rst_b_ready", 64'(mstReq.b_ready), 64'd1);
    checkOutput("rst_r_ready", 64'(mstReq.r_ready), 64'd1);
    checkOutput("rst_aw_valid", 64'(mstReq.aw_valid), 64'd0);
    checkOutput("rst_r_valid", 64'(slvResp.r_valid), 64'd0);
    checkOutput("rst_aw_payload", 64'(mstReq.aw), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Zero latency: visible exactly one cycle after acceptance.
    applyStimulus(0, 32'h1000);
    checkOutput("t1_aw_valid", 64'(mstReq.aw_valid), 64'd1);
    checkOutput("t1_aw_addr", 64'(mstReq.aw.addr), 64'h1000);
    step();
    checkOutput("t1_aw_gone", 64'(mstReq.aw_valid), 64'd0);

    reqLat = 8'd5;
    applyStimulus(2, 32'hA0);
    measure(2, n);
    checkOutput("t2_ar_latency", 64'(n), 64'd5);
    checkOutput("t2_ar_addr", 64'(mstReq.ar.addr), 64'hA0);
    step();
    respLat = 8'd3;
    applyStimulus(4, 32'hD00D);
    measure(4, n);
    checkOutput("t2_r_latency", 64'(n), 64'd3);
    checkOutput("t2_r_data", 64'(slvResp.r.data), 64'hD00D);
    step();
    reqLat  = 8'd0;
    respLat = 8'd0;

    // Backpressure fills the W FIFO, then drain in order.
    mstResp.w_ready = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      slvReq.w_valid = 1'b1;
      slvReq.w.data  = 32'(accepted + 1);
      acc = slvResp.w_ready;
      step();
      if (acc) accepted++;
    end
    checkOutput("t3_accepted", 64'(accepted), 64'd4);
    checkOutput("t3_w_ready_full", 64'(slvResp.w_ready), 64'd0);
    mstResp.w_ready = 1'b1;
    sent = accepted;
    for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
      slvReq.w_valid = (sent < 6);
      slvReq.w.data  = 32'(sent + 1);
      acc = slvReq.w_valid && slvResp.w_ready;
      if (cyc == 0) checkOutput("t3_ready_during_pop", 64'(slvResp.w_ready), 64'd0);
      if (cyc == 1) checkOutput("t3_ready_after_pop", 64'(slvResp.w_ready), 64'd1);
      if (mstReq.w_valid) got.push_back(mstReq.w.data);
      step();
      if (acc) sent++;
    end
    slvReq.w_valid = 1'b0;
    checkOutput("t3_drained", 64'(got.size()), 64'd6);
    for (int i = 0; i < got.size(); i++) checkOutput("t3_order", 64'(got[i]), 64'(i + 1));

    // Head-of-line: B has a shorter latency but must wait for A.
    reqLat = 8'd8;
    applyStimulus(0, 32'hA);
    reqLat = 8'd1;
    applyStimulus(0, 32'hB);
    measure(0, n);
    checkOutput("t4_a_wait", 64'(n), 64'd7);
    checkOutput("t4_a_addr", 64'(mstReq.aw.addr), 64'hA);
    step();
    checkOutput("t4_b_valid", 64'(mstReq.aw_valid), 64'd1);
    checkOutput("t4_b_addr", 64'(mstReq.aw.addr), 64'hB);
    step();
    checkOutput("t4_empty", 64'(mstReq.aw_valid), 64'd0);
    reqLat = 8'd0;

    // Jittered latency must stay within [250,255] and hit the saturation cap.
    reqLat = 8'd250;
    reqJit = 8'h0F;
    minL   = 1000;
    maxL   = 0;
    sawSat = 1'b0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(2, 32'(i));
      measure(2, n);
      if (n < minL) minL = n;
      if (n > maxL) maxL = n;
      if (n == 255) sawSat = 1'b1;
      step();
    end
    checkOutput("t5_min_ge_250", 64'(minL >= 250), 64'd1);
    checkOutput("t5_max_le_255", 64'(maxL <= 255), 64'd1);
    checkOutput("t5_saturated", 64'(sawSat), 64'd1);
    reqLat = 8'd0;
    reqJit = 8'd0;

    // Asynchronous reset with a full B FIFO.
    slvReq.b_ready = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(3, 32'(k));
    checkOutput("t6_pre_b_valid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("t6_pre_b_ready", 64'(mstReq.b_ready), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_b_valid", 64'(slvResp.b_valid), 64'd0);
    checkOutput("t6_rst_b_ready", 64'(mstReq.b_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    slvReq.b_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (slvResp.b_valid) seen++;
      step();
    end
    checkOutput("t6_no_stale_beats", 64'(seen), 64'd0);
    applyStimulus(3, 32'h5);
    measure(3, n);
    checkOutput("t6_new_latency", 64'(n), 64'd0);
    checkOutput("t6_new_id", 64'(slvResp.b.id), 64'h5);
    step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
